// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and fill-sequencer state type for the I-cache refill path.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_DONE,
    ST_ERR
  } fill_state_t;

  // Burst type that exactly covers one cache line of 32-bit beats.
  function automatic logic [2:0] burst_for_line(input int line_bits);
    case (line_bits)
      256:     return HBURST_INCR8;
      512:     return HBURST_INCR16;
      default: return HBURST_INCR4;
    endcase
  endfunction

endpackage

// File: rtl/ahb_line_fill_ctrl.sv
// I-cache line refill sequencer: one aligned INCR burst per miss, beats assembled
// into a line register, completion or bus error reported with a one-cycle pulse.
module ahb_line_fill_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned CACHE_LINE = 128,
  parameter logic [3:0]  HPROT_VAL  = 4'b0010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_req,
  input  logic [31:0]           fill_addr,
  output logic [CACHE_LINE-1:0] fill_line,
  output logic                  fill_done,
  output logic                  fill_err,
  output logic                  busy,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  output logic [3:0]            HPROT,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int unsigned BEATS     = CACHE_LINE / 32;
  localparam int unsigned IW        = $clog2(BEATS);
  localparam int unsigned CW        = IW + 1;
  localparam logic [31:0] OFF_MASK  = 32'(CACHE_LINE / 8 - 1);
  localparam logic [2:0]  BURST_VAL = burst_for_line(CACHE_LINE);

  fill_state_t   state;
  logic [CW-1:0] addr_cnt;
  logic [CW-1:0] data_cnt;
  logic [31:0]   slots [BEATS];
  logic          capture;

  // A data phase is outstanding in every BURST/LAST cycle; OKAY+ready completes it.
  assign capture = ((state == ST_BURST) || (state == ST_LAST)) && HREADY && !HRESP;

  for (genvar g = 0; g < int'(BEATS); g++) begin : g_line
    assign fill_line[32*g +: 32] = slots[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr_cnt  <= '0;
      data_cnt  <= '0;
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HBURST    <= '0;
      HSIZE     <= '0;
      HWRITE    <= 1'b0;
      HPROT     <= '0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(BEATS); i++) slots[i] <= '0;
    end else begin
      HBURST    <= BURST_VAL;
      HSIZE     <= HSIZE_WORD;
      HWRITE    <= 1'b0;
      HPROT     <= HPROT_VAL;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;

      if (capture) begin
        slots[data_cnt[IW-1:0]] <= HRDATA;
        data_cnt                <= data_cnt + CW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (fill_req) begin
            HADDR    <= fill_addr & ~OFF_MASK;
            HTRANS   <= HTRANS_NONSEQ;
            addr_cnt <= '0;
            data_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (HREADY) begin
            addr_cnt <= addr_cnt + CW'(1);
            HADDR    <= HADDR + 32'd4;
            HTRANS   <= HTRANS_SEQ;
            state    <= ST_BURST;
          end
        end

        ST_BURST, ST_LAST: begin
          // Two-cycle ERROR: cancel on the first cycle, abort on the second.
          if (HRESP) begin
            HTRANS <= HTRANS_IDLE;
            if (HREADY) begin
              fill_err <= 1'b1;
              state    <= ST_ERR;
            end
          end else if (HREADY) begin
            if (state == ST_LAST) begin
              if (data_cnt == CW'(BEATS - 1)) begin
                fill_done <= 1'b1;
                state     <= ST_DONE;
              end
            end else if (addr_cnt == CW'(BEATS - 1)) begin
              HTRANS <= HTRANS_IDLE;
              state  <= ST_LAST;
            end else begin
              addr_cnt <= addr_cnt + CW'(1);
              HADDR    <= HADDR + 32'd4;
              HTRANS   <= HTRANS_SEQ;
            end
          end
        end

        ST_DONE, ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  req_held_a: assert property (@(posedge clk) disable iff (!rst)
    (state inside {ST_ADDR, ST_BURST, ST_LAST}) |-> fill_req);

  pulse_excl_a: assert property (@(posedge clk) disable iff (!rst)
    !(fill_done && fill_err));

endmodule
